// File: rtl/fb_addr_gen.sv
// Frame-buffer scan address generator with integer pixel/line replication.
// Optional double buffering is enabled by defining FB_DOUBLE_BUFFER_EN.
module fb_addr_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int SCALE_LOG2 = 0,
    parameter int ADDR_W     = 20,
    parameter int BASE0      = 0,
    parameter int BASE1      = 307200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              video_on,
    input  logic              frame_start,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              active_buf,
    output logic [ADDR_W-1:0] addr,
    output logic              line_end,
    output logic              frame_done
);

    localparam int X_W   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int Y_W   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int REP_W = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;

    localparam logic [X_W-1:0]    X_LAST   = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0]    Y_LAST   = Y_W'(V_ACTIVE - 1);
    localparam logic [REP_W-1:0]  REP_LAST = REP_W'((1 << SCALE_LOG2) - 1);
    localparam logic [ADDR_W-1:0] SRC_W    = ADDR_W'(H_ACTIVE >> SCALE_LOG2);
    localparam logic [ADDR_W-1:0] B0       = ADDR_W'(BASE0);
    localparam logic [ADDR_W-1:0] B1       = ADDR_W'(BASE1);

    logic [X_W-1:0]    x_q, x_n;
    logic [Y_W-1:0]    y_q, y_n;
    logic [REP_W-1:0]  rep_x_q, rep_x_n, rep_y_q, rep_y_n;
    logic [ADDR_W-1:0] line_base_q, line_base_n, addr_q, addr_n;
    logic              buf_q, buf_n, ack_q, ack_n;
    logic              line_end_q, line_end_n, frame_done_q, frame_done_n;

    // take_swap is only honoured at frame boundaries; base_sw is the base in effect after it
    logic              take_swap;
    logic [ADDR_W-1:0] base_sw;

`ifdef FB_DOUBLE_BUFFER_EN
    assign take_swap = swap_req;
    assign base_sw   = (buf_q ^ swap_req) ? B1 : B0;
`else
    logic unused_swap;
    assign unused_swap = swap_req ^ (|B1);
    assign take_swap   = 1'b0;
    assign base_sw     = B0;
`endif

    always_comb begin
        x_n          = x_q;
        y_n          = y_q;
        rep_x_n      = rep_x_q;
        rep_y_n      = rep_y_q;
        line_base_n  = line_base_q;
        addr_n       = addr_q;
        buf_n        = buf_q;
        ack_n        = 1'b0;
        line_end_n   = 1'b0;
        frame_done_n = 1'b0;

        if (en) begin
            if (frame_start) begin
                x_n         = '0;
                y_n         = '0;
                rep_x_n     = '0;
                rep_y_n     = '0;
                buf_n       = buf_q ^ take_swap;
                ack_n       = take_swap;
                line_base_n = base_sw;
                addr_n      = base_sw;
            end else if (video_on) begin
                if (x_q == X_LAST) begin
                    x_n        = '0;
                    rep_x_n    = '0;
                    line_end_n = 1'b1;
                    if (y_q == Y_LAST) begin
                        y_n          = '0;
                        rep_y_n      = '0;
                        frame_done_n = 1'b1;
                        buf_n        = buf_q ^ take_swap;
                        ack_n        = take_swap;
                        line_base_n  = base_sw;
                        addr_n       = base_sw;
                    end else begin
                        y_n = y_q + 1'b1;
                        if (rep_y_q == REP_LAST) begin
                            rep_y_n     = '0;
                            line_base_n = line_base_q + SRC_W;
                        end else begin
                            rep_y_n = rep_y_q + 1'b1;
                        end
                        addr_n = line_base_n;
                    end
                end else begin
                    x_n = x_q + 1'b1;
                    if (rep_x_q == REP_LAST) begin
                        rep_x_n = '0;
                        addr_n  = addr_q + 1'b1;
                    end else begin
                        rep_x_n = rep_x_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q          <= '0;
            y_q          <= '0;
            rep_x_q      <= '0;
            rep_y_q      <= '0;
            line_base_q  <= B0;
            addr_q       <= B0;
            buf_q        <= 1'b0;
            ack_q        <= 1'b0;
            line_end_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            x_q          <= x_n;
            y_q          <= y_n;
            rep_x_q      <= rep_x_n;
            rep_y_q      <= rep_y_n;
            line_base_q  <= line_base_n;
            addr_q       <= addr_n;
            buf_q        <= buf_n;
            ack_q        <= ack_n;
            line_end_q   <= line_end_n;
            frame_done_q <= frame_done_n;
        end
    end

    assign addr       = addr_q;
    assign active_buf = buf_q;
    assign swap_ack   = ack_q;
    assign line_end   = line_end_q;
    assign frame_done = frame_done_q;

endmodule
